uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; it SHALL be an even value of at least 4.
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning a parity bit follows the data bits when set.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL have the following ports:
  - clk  input  1  the single clock.
  - rst  input  1  reset, synchronous and active-high.
  - Rx  input  1  asynchronous serial line, idle high.
  - BIST_Mode  input  1  when high, frame reception is suppressed.
  - Rx_Data  output  DATA_BITS  last received data word.
  - Data_Rdy  output  1  one-cycle pulse: Rx_Data holds a new valid word.
  - Framing_Err  output  1  the last completed frame had a low stop bit.
  - Parity_Err  output  1  the last completed frame had a parity mismatch.
  - Rx_Busy  output  1  the FSM is not IDLE.

Function
REQ-006 Rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-007 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a bit-timing counter of width clog2(CLKS_PER_BIT) and a bit index of width clog2(DATA_BITS).
REQ-008 In IDLE, when rx_s is 0, the FSM SHALL enter START and clear the counter.
REQ-009 In START, at counter = CLKS_PER_BIT/2-1, the FSM SHALL check rx_s:
  - if rx_s=0, enter DATA and clear the counter and bit index;
  - if rx_s=1, treat it as a false start, return to IDLE and assert no outputs.
REQ-010 In DATA, every CLKS_PER_BIT cycles, the block SHALL sample rx_s into the shift register LSB-first and increment the bit index. After bit DATA_BITS-1 it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-011 In PARITY, after CLKS_PER_BIT cycles, the block SHALL sample the parity bit. The expected bit is XOR(data) XOR PARITY_ODD. The FSM SHALL then go to STOP.
REQ-012 In STOP, after CLKS_PER_BIT cycles, the block SHALL sample the stop bit at mid-bit and return to IDLE in the same cycle; it SHALL NOT wait for the end of the stop bit.
REQ-013 At the stop sample:
  - Framing_Err SHALL be set to (stop bit == 0).
  - Parity_Err SHALL be set to the parity mismatch, or 0 when PARITY_EN=0.
  - Both SHALL hold until the next stop sample or reset.
REQ-014 Rx_Data SHALL be updated and Data_Rdy pulsed for exactly one cycle on the cycle after the stop sample, only when both errors are clear. An errored frame SHALL leave Rx_Data unchanged.
REQ-015 Latency from the stop-bit sample to Data_Rdy SHALL be exactly 1 clk.
REQ-016 A start edge arriving in the cycle after the return to IDLE SHALL be accepted, so back-to-back frames with one stop bit are received without loss.
REQ-017 While BIST_Mode=1 in IDLE, the FSM SHALL stay in IDLE.
REQ-018 If BIST_Mode rises mid-frame, the FSM SHALL abort to IDLE with no Data_Rdy and with the error flags unchanged.
REQ-019 Rx_Busy SHALL be 1 in every state except IDLE.
REQ-020 Data_Rdy SHALL NOT be asserted in two consecutive cycles.

Reset
REQ-021 On rst=1 at a clk edge:
  - the FSM SHALL go to IDLE and clear the counter and bit index;
  - both synchronizer flops SHALL be set to 1;
  - Rx_Data='0, Data_Rdy=0, Framing_Err=0, Parity_Err=0, Rx_Busy=0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame. The next frame after reset deasserts SHALL be received normally.

Verification
REQ-023 Frame 0xA5 (8N1, CLKS_PER_BIT=16): Data_Rdy pulses exactly once, 1 clk after the stop sample; Rx_Data=0xA5; both error flags are 0.
REQ-024 Rx low for 4 clks, then high: no Data_Rdy, Rx_Busy returns to 0, FSM in IDLE by clk 8.
REQ-025 Frame 0x3C with stop bit 0: Framing_Err=1, no Data_Rdy, Rx_Data keeps its previous value. A following good frame 0x11 clears Framing_Err and gives Rx_Data=0x11.
REQ-026 PARITY_EN=1, PARITY_ODD=0, frame 0x07 with parity bit 0: Parity_Err=1, no Data_Rdy. The same frame with parity bit 1 gives Data_Rdy and Rx_Data=0x07.
REQ-027 Back-to-back frames 0x00 then 0xFF with no idle gap: two Data_Rdy pulses, Rx_Data=0x00 then 0xFF.
REQ-028 rst pulsed during data bit 3 of frame 0x55: all outputs are at their reset values; the next frame 0x81 yields Data_Rdy with Rx_Data=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, optional parity,
// single stop bit checked at mid-bit so back-to-back frames are not lost.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Framing_Err,
  output logic                 Parity_Err,
  output logic                 Rx_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_r, state_nxt;
  logic                   rx_meta_r, rx_s;
  logic [CW-1:0]          cnt_r, cnt_nxt;
  logic [IW-1:0]          idx_r, idx_nxt;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_bit_r;
  logic                   take_data_s, take_par_s, take_stop_s;
  logic                   frame_err_s, par_mis_s;

  function automatic logic xor_reduce(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  assign frame_err_s = ~rx_s;
  assign par_mis_s   = (PARITY_EN != 0) ? (par_bit_r != (xor_reduce(shift_r) ^ ODD_BIT)) : 1'b0;

  // Two-flop synchronizer, idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= Rx;
      rx_s      <= rx_meta_r;
    end
  end

  // State, bit-timer and bit-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      idx_r   <= idx_nxt;
    end
  end

  // Next-state logic and sampling strobes; BIST_Mode aborts any frame in flight.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    idx_nxt     = idx_r;
    take_data_s = 1'b0;
    take_par_s  = 1'b0;
    take_stop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!BIST_Mode && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (BIST_Mode) begin
          state_nxt = IDLE;
        end else if (cnt_r == HALF_LAST) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (BIST_Mode) begin
          state_nxt = IDLE;
        end else if (cnt_r == BIT_LAST) begin
          take_data_s = 1'b1;
          cnt_nxt     = '0;
          idx_nxt     = idx_r + IW'(1);
          if (idx_r == IDX_LAST) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      PARITY: begin
        if (BIST_Mode) begin
          state_nxt = IDLE;
        end else if (cnt_r == BIT_LAST) begin
          take_par_s = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = STOP;
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (BIST_Mode) begin
          state_nxt = IDLE;
        end else if (cnt_r == BIT_LAST) begin
          take_stop_s = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Shift register, parity capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r     <= '0;
      par_bit_r   <= 1'b0;
      Rx_Data     <= '0;
      Data_Rdy    <= 1'b0;
      Framing_Err <= 1'b0;
      Parity_Err  <= 1'b0;
      Rx_Busy     <= 1'b0;
    end else begin
      Data_Rdy <= 1'b0;
      Rx_Busy  <= (state_nxt != IDLE);
      if (take_data_s) begin
        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      end
      if (take_par_s) begin
        par_bit_r <= rx_s;
      end
      if (take_stop_s) begin
        Framing_Err <= frame_err_s;
        Parity_Err  <= par_mis_s;
        if (!frame_err_s && !par_mis_s) begin
          Rx_Data  <= shift_r;
          Data_Rdy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance and an 8E1 instance share
// the serial line; frames are checked against a rule-level receive model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = CPB / 2 + 3;   // stop-bit start to Data_Rdy: mid-bit, 2 sync flops, 1 output reg

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       bist = 1'b0;
  logic [7:0] m_data_o, p_data_o;
  logic       m_rdy, m_ferr, m_perr, m_busy;
  logic       p_rdy, p_ferr, p_perr, p_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stop_cyc = 0;
  logic [7:0] m_q[$];
  int         m_cyc_q[$];
  logic [7:0] p_q[$];
  logic       m_prev = 1'b0, p_prev = 1'b0;

  // reference model state
  logic [7:0] m_data = 8'h00;
  logic [7:0] p_data = 8'h00;

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .Rx(rx), .BIST_Mode(bist),
    .Rx_Data(m_data_o), .Data_Rdy(m_rdy), .Framing_Err(m_ferr),
    .Parity_Err(m_perr), .Rx_Busy(m_busy));

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .Rx(rx), .BIST_Mode(bist),
    .Rx_Data(p_data_o), .Data_Rdy(p_rdy), .Framing_Err(p_ferr),
    .Parity_Err(p_perr), .Rx_Busy(p_busy));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every Data_Rdy pulse; a pulse on two consecutive cycles is an error.
  always @(negedge clk) begin
    if (m_rdy) begin
      m_q.push_back(m_data_o);
      m_cyc_q.push_back(cyc);
      checks++;
      if (m_prev) begin
        errors++;
        $display("FAIL m_rdy_consecutive: got 2 cycles expected 1 at cyc %0d", cyc);
      end
    end
    if (p_rdy) begin
      p_q.push_back(p_data_o);
      checks++;
      if (p_prev) begin
        errors++;
        $display("FAIL p_rdy_consecutive: got 2 cycles expected 1 at cyc %0d", cyc);
      end
    end
    m_prev = m_rdy;
    p_prev = p_rdy;
  end

  function automatic logic even_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2 == 1);
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par);
    stop_cyc = cyc;
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", m_data_o); end
    checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", m_rdy); end
    checks++; if (m_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", m_ferr); end
    checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", m_perr); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_good_frame();
    m_q.delete(); m_cyc_q.delete();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    m_data = 8'hA5;
    checks++;
    if (m_q.size() != 1) begin
      errors++; $display("FAIL a5_pulses: got %0d expected 1", m_q.size());
    end else begin
      checks++; if (m_q[0] !== 8'hA5) begin errors++; $display("FAIL a5_pulse_data: got %h expected a5", m_q[0]); end
      checks++; if (m_cyc_q[0] - stop_cyc != LAT) begin errors++; $display("FAIL a5_latency: got %0d expected %0d", m_cyc_q[0] - stop_cyc, LAT); end
    end
    checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL a5_data: got %h expected %h", m_data_o, m_data); end
    checks++; if (m_ferr !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b expected 0", m_ferr); end
    checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL a5_perr: got %b expected 0", m_perr); end
    idle(4);
  endtask

  task automatic test_false_start();
    m_q.delete();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_hi: got %b expected 1", m_busy); end
    repeat (8) @(negedge clk);
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_lo: got %b expected 0", m_busy); end
    idle(CPB * 2);
    checks++; if (m_q.size() != 0) begin errors++; $display("FAIL false_start_pulses: got %0d expected 0", m_q.size()); end
    checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL false_start_data: got %h expected %h", m_data_o, m_data); end
  endtask

  task automatic test_framing();
    m_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (m_ferr !== 1'b1) begin errors++; $display("FAIL frm_ferr_set: got %b expected 1", m_ferr); end
    checks++; if (m_q.size() != 0) begin errors++; $display("FAIL frm_pulses: got %0d expected 0", m_q.size()); end
    checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL frm_data_kept: got %h expected %h", m_data_o, m_data); end
    idle(CPB * 2);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    m_data = 8'h11;
    checks++; if (m_ferr !== 1'b0) begin errors++; $display("FAIL frm_ferr_clr: got %b expected 0", m_ferr); end
    checks++; if (m_q.size() != 1) begin errors++; $display("FAIL frm_good_pulses: got %0d expected 1", m_q.size()); end
    checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL frm_good_data: got %h expected %h", m_data_o, m_data); end
    idle(4);
  endtask

  task automatic test_bist();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(CPB * 2);
    m_q.delete();
    bist = 1'b1;
    fork
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      begin
        repeat (CPB * 3) @(negedge clk);
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL bist_idle_busy: got %b expected 0", m_busy); end
      end
    join
    bist = 1'b0;
    idle(4);
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        repeat (CPB * 5) @(negedge clk);
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL bist_mid_busy_hi: got %b expected 1", m_busy); end
        bist = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL bist_abort_busy: got %b expected 0", m_busy); end
      end
    join
    bist = 1'b0;
    idle(CPB * 2);
    checks++; if (m_q.size() != 0) begin errors++; $display("FAIL bist_pulses: got %0d expected 0", m_q.size()); end
    checks++; if (m_ferr !== 1'b1) begin errors++; $display("FAIL bist_ferr_kept: got %b expected 1", m_ferr); end
    checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL bist_data_kept: got %h expected %h", m_data_o, m_data); end
  endtask

  task automatic test_back_to_back();
    m_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    m_data = 8'hFF;
    checks++;
    if (m_q.size() != 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d expected 2", m_q.size());
    end else begin
      checks++; if (m_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", m_q[0]); end
      checks++; if (m_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", m_q[1]); end
    end
    checks++; if (m_ferr !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b expected 0", m_ferr); end
    idle(4);
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic       par, ok;
    idle(CPB * 12);
    p_q.delete();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    checks++; if (p_perr !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b expected 1", p_perr); end
    checks++; if (p_q.size() != 0) begin errors++; $display("FAIL par_bad_pulses: got %0d expected 0", p_q.size()); end
    idle(4);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    p_data = 8'h07;
    checks++; if (p_perr !== 1'b0) begin errors++; $display("FAIL par_good_perr: got %b expected 0", p_perr); end
    checks++; if (p_q.size() != 1) begin errors++; $display("FAIL par_good_pulses: got %0d expected 1", p_q.size()); end
    checks++; if (p_data_o !== p_data) begin errors++; $display("FAIL par_good_data: got %h expected %h", p_data_o, p_data); end
    for (int n = 0; n < 10; n++) begin
      idle(4);
      p_q.delete();
      d   = 8'($urandom_range(0, 255));
      par = even_par(d) ^ ($urandom_range(0, 2) == 0);
      ok  = (par == even_par(d));
      send_frame(d, 1'b1, par, 1'b1);
      if (ok) p_data = d;
      checks++; if (p_perr !== !ok) begin errors++; $display("FAIL par_rand_perr[%0d]: got %b expected %b", n, p_perr, !ok); end
      checks++; if (p_q.size() != (ok ? 1 : 0)) begin errors++; $display("FAIL par_rand_pulses[%0d]: got %0d expected %0d", n, p_q.size(), ok ? 1 : 0); end
      checks++; if (p_data_o !== p_data) begin errors++; $display("FAIL par_rand_data[%0d]: got %h expected %h", n, p_data_o, p_data); end
    end
    idle(CPB * 2);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    for (int n = 0; n < 20; n++) begin
      m_q.delete(); m_cyc_q.delete();
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, 1'b0, 1'b0, stop);
      if (stop) m_data = d;
      checks++; if (m_ferr !== !stop) begin errors++; $display("FAIL rand_ferr[%0d]: got %b expected %b", n, m_ferr, !stop); end
      checks++; if (m_q.size() != (stop ? 1 : 0)) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d", n, m_q.size(), stop ? 1 : 0); end
      checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, m_data_o, m_data); end
      if (stop && m_cyc_q.size() == 1) begin
        checks++; if (m_cyc_q[0] - stop_cyc != LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, m_cyc_q[0] - stop_cyc, LAT); end
      end
      idle(stop ? $urandom_range(0, 3) : CPB * 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h55;
    m_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    m_data = 8'h00;
    checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", m_data_o); end
    checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy: got %b expected 0", m_rdy); end
    checks++; if (m_ferr !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr: got %b expected 0", m_ferr); end
    checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL mid_rst_perr: got %b expected 0", m_perr); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", m_busy); end
    rst = 1'b0;
    idle(CPB * 12);
    checks++; if (m_q.size() != 0) begin errors++; $display("FAIL mid_rst_pulses: got %0d expected 0", m_q.size()); end
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    m_data = 8'h81;
    checks++; if (m_q.size() != 1) begin errors++; $display("FAIL post_rst_pulses: got %0d expected 1", m_q.size()); end
    checks++; if (m_data_o !== m_data) begin errors++; $display("FAIL post_rst_data: got %h expected %h", m_data_o, m_data); end
    idle(4);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing();
    test_bist();
    test_back_to_back();
    test_parity();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
